// File: rtl/en_sched_pkg.sv
// Shared types and default sizing for the enable scheduler.
// The state enum is common to the top level and any bench that peeks at it.
package en_sched_pkg;

   localparam int N_REQ_DEF  = 4;
   localparam int CNT_W_DEF  = 8;
   localparam int MISS_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } t_sched_state;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: grants the first requester strictly after
// the last-granted pointer, wrapping from N_REQ-1 back to 0.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic             valid
);

   always_comb begin : arb_search
      logic [PTR_W-1:0] idx;
      grant = '0;
      valid = 1'b0;
      idx   = ptr;
      // Walk N_REQ positions starting one past the pointer; the pointer itself
      // is visited last so a lone requester can be granted repeatedly.
      for (int k = 0; k < N_REQ; k++) begin
         if (idx == PTR_W'(N_REQ - 1)) begin
            idx = '0;
         end else begin
            idx = idx + 1'b1;
         end
         if (!valid && req[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/en_sched.sv
// Prescaled round-robin enable scheduler: every ratio cycles of RUN it emits a
// tick and a one-hot enable to the next requesting client.
module en_sched
   import en_sched_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int MISS_W = MISS_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CNT_W-1:0]  cfg_ratio,
   input  logic              cfg_load,
   input  logic              run,
   input  logic [N_REQ-1:0]  req,
   output logic [N_REQ-1:0]  o_en,
   output logic              tick,
   output logic              busy,
   output logic [MISS_W-1:0] miss_cnt,
   output logic              cfg_err
);

   localparam int               PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);

   t_sched_state      state_q, state_d;
   logic [CNT_W-1:0]  presc_q, presc_d;
   logic [CNT_W-1:0]  ratio_q, ratio_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [N_REQ-1:0]  o_en_q, o_en_d;
   logic              tick_q, tick_d;
   logic [MISS_W-1:0] miss_q, miss_d;
   logic              err_q, err_d;

   logic [N_REQ-1:0]  arb_grant;
   logic              arb_valid;
   logic [PTR_W-1:0]  grant_idx;
   logic              term_cnt;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req   (req),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   // Terminal count only exists in RUN; the tick it launches may land in DRAIN.
   assign term_cnt = (state_q == RUN) && (presc_q == (ratio_q - 1'b1));

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_grant[i]) begin
            grant_idx = PTR_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (run)  state_d = RUN;
         RUN:     if (!run) state_d = DRAIN;
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      presc_d = '0;
      ratio_d = ratio_q;
      err_d   = err_q;
      ptr_d   = ptr_q;
      miss_d  = miss_q;
      tick_d  = term_cnt;
      o_en_d  = term_cnt ? arb_grant : '0;

      if ((state_q == RUN) && run && !term_cnt) begin
         presc_d = presc_q + 1'b1;
      end

      if (cfg_load) begin
         if (state_q == IDLE) begin
            ratio_d = (cfg_ratio == '0) ? CNT_W'(1) : cfg_ratio;
         end else begin
            err_d = 1'b1;
         end
      end

      if (term_cnt) begin
         if (arb_valid) begin
            ptr_d = grant_idx;
         end else if (miss_q != '1) begin
            miss_d = miss_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         ratio_q <= CNT_W'(1);
         ptr_q   <= PTR_RST;
         o_en_q  <= '0;
         tick_q  <= 1'b0;
         miss_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         presc_q <= presc_d;
         ratio_q <= ratio_d;
         ptr_q   <= ptr_d;
         o_en_q  <= o_en_d;
         tick_q  <= tick_d;
         miss_q  <= miss_d;
         err_q   <= err_d;
      end
   end

   assign o_en     = o_en_q;
   assign tick     = tick_q;
   assign busy     = (state_q != IDLE);
   assign miss_cnt = miss_q;
   assign cfg_err  = err_q;

`ifndef SYNTHESIS
   a_en_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(o_en_q));
   a_en_tick   : assert property (@(posedge clk) disable iff (!rst_n) (o_en_q != '0) |-> tick_q);
   a_ratio_nz  : assert property (@(posedge clk) disable iff (!rst_n) ratio_q != '0);
`endif

endmodule
